// File: rtl/serial_addsub_if.sv
// serial_addsub_if: operand/result handshake bundle for the digit-serial adder/subtractor.
// slave modport faces the arithmetic block, master modport faces the producer/consumer side.
interface serial_addsub_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out;

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  op,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out
    );

    modport master (
        output in_valid,
        output a,
        output b,
        output op,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out
    );
endinterface

// File: rtl/serial_addsub.sv
// serial_addsub: digit-serial unsigned adder/subtractor, DIGIT bits per clock.
// Subtraction is a + ~b + 1 with the carry register seeded to 1; the top result
// bit is the carry for add and the inverted carry (borrow) for subtract.
// Optional feature macro: ADDSUB_SAT_EN (saturating results, top bit becomes the
// saturation flag). Without it results wrap around.
module serial_addsub #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    serial_addsub_if.slave  bus
);
    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_op;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH:0]   r_out;

    logic [DIGIT:0]   w_sum;
    logic [WIDTH-1:0] w_res;
    logic             w_top;
    logic             w_last;
    logic [WIDTH:0]   w_final;

    // One digit slice: sum of the low digits plus carry, result shifted in from the top.
    always_comb begin
        w_sum   = (DIGIT+1)'(r_a[DIGIT-1:0]) + (DIGIT+1)'(r_b[DIGIT-1:0]) + (DIGIT+1)'(r_carry);
        w_res   = (r_out[WIDTH-1:0] >> DIGIT) | (WIDTH'(w_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
        w_top   = r_op ? ~w_sum[DIGIT] : w_sum[DIGIT];
        w_last  = (r_cnt == CW'(N - 1));
        w_final = {w_top, w_res};
`ifdef ADDSUB_SAT_EN
        // Overflow clamps to all ones, underflow to zero; top bit then flags saturation.
        if (w_top) begin
            w_final = {1'b1, (r_op ? {WIDTH{1'b0}} : {WIDTH{1'b1}})};
        end
`endif
    end

    // Control FSM with operand shift registers and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= 1'b0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a        <= bus.a;
                        r_b        <= bus.op ? ~bus.b : bus.b;
                        r_op       <= bus.op;
                        r_carry    <= bus.op;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_carry <= w_sum[DIGIT];
                    if (w_last) begin
                        r_out       <= w_final;
                        r_cnt       <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_out[WIDTH-1:0] <= w_res;
                        r_cnt            <= r_cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out       = r_out;
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: directed and random checks of serial_addsub for DIGIT = 1, 2, 4, 8.
// Instance g uses DIGIT = 1 << g; directed tests run on the DIGIT = 2 instance.
module tb_serial_addsub;
    localparam int unsigned W = 8;

`ifdef ADDSUB_SAT_EN
    localparam logic [W:0] E_ADD = 9'h1FF;
    localparam logic [W:0] E_SUB = 9'h100;
    localparam logic [W:0] E_BP  = 9'h1FF;
`else
    localparam logic [W:0] E_ADD = 9'h12C;
    localparam logic [W:0] E_SUB = 9'h1FC;
    localparam logic [W:0] E_BP  = 9'h1FE;
`endif
    localparam logic [W:0] E_77 = 9'd14;

    logic           clk;
    logic           rst_n;
    logic [3:0]     drv_valid;
    logic [3:0]     drv_op;
    logic [3:0]     drv_ordy;
    logic [W-1:0]   drv_a [4];
    logic [W-1:0]   drv_b [4];
    wire  [3:0]     mon_in_ready;
    wire  [3:0]     mon_out_valid;
    wire  [W:0]     mon_out [4];

    int             n_pass = 0;
    int             n_tot  = 0;
    int             cyc    = 0;
    logic [W:0]     exp_q [4];
    int             acc [4];
    logic [3:0]     pend   = '0;
    logic [3:0]     prev_v = '0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        serial_addsub_if #(.WIDTH(W)) bus ();
        assign bus.in_valid  = drv_valid[g];
        assign bus.a         = drv_a[g];
        assign bus.b         = drv_b[g];
        assign bus.op        = drv_op[g];
        assign bus.out_ready = drv_ordy[g];
        assign mon_in_ready[g]  = bus.in_ready;
        assign mon_out_valid[g] = bus.out_valid;
        assign mon_out[g]       = bus.out;
        serial_addsub #(.WIDTH(W), .DIGIT(1 << g)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: exact W+1-bit arithmetic, optionally saturated.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
        logic [W:0] r;
        if (!op) r = {1'b0, a} + {1'b0, b};
        else     r = {1'b0, a} - {1'b0, b};
`ifdef ADDSUB_SAT_EN
        if (!op && r[W]) r = {1'b1, {W{1'b1}}};
        if (op && (a < b)) r = {1'b1, {W{1'b0}}};
`endif
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_tot++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    endtask

    // Scoreboard compare: record accepted ops, check result, latency and handshake each cycle.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (!rst_n) begin
                pend[k]   = 1'b0;
                prev_v[k] = 1'b0;
            end else begin
                if (mon_out_valid[k]) begin
                    chk("out_valid only for accepted op", 64'(pend[k]), 64'd1);
                    chk("result", 64'(mon_out[k]), 64'(exp_q[k]));
                    chk("in_ready low while out_valid", 64'(mon_in_ready[k]), 64'd0);
                    if (!prev_v[k]) chk("latency", 64'(cyc - acc[k]), 64'(W >> k));
                    if (drv_ordy[k]) pend[k] = 1'b0;
                end else if (pend[k]) begin
                    chk("result not late", 64'((cyc - acc[k]) < int'(W >> k)), 64'd1);
                    if ((cyc - acc[k]) >= int'(W >> k)) pend[k] = 1'b0;
                end
                if (drv_valid[k] && mon_in_ready[k]) begin
                    exp_q[k] = model(drv_a[k], drv_b[k], drv_op[k]);
                    acc[k]   = cyc + 1;
                    pend[k]  = 1'b1;
                end
                prev_v[k] = mon_out_valid[k];
            end
        end
    end

    task automatic send(input int k, input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
        int t = 0;
        while (!mon_in_ready[k] && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (!mon_in_ready[k]) begin
            n_tot++;
            $display("FAIL in_ready wait (instance %0d): got 0, expected 1", k);
            return;
        end
        drv_a[k]     = a;
        drv_b[k]     = b;
        drv_op[k]    = op;
        drv_valid[k] = 1'b1;
        @(posedge clk); #1;
        drv_valid[k] = 1'b0;
    endtask

    task automatic wait_out(input int k, output int lat);
        lat = 0;
        while (!mon_out_valid[k] && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_out(input int k);
        drv_ordy[k] = 1'b1;
        @(posedge clk); #1;
        drv_ordy[k] = 1'b0;
        chk("in_ready after output transfer", 64'(mon_in_ready[k]), 64'd1);
        chk("out_valid after output transfer", 64'(mon_out_valid[k]), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        clk       = 1'b0;
        rst_n     = 1'b1;
        drv_valid = '0;
        drv_op    = '0;
        drv_ordy  = '0;
        for (int k = 0; k < 4; k++) begin
            drv_a[k] = '0;
            drv_b[k] = '0;
        end
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            chk("reset in_ready", 64'(mon_in_ready[k]), 64'd1);
            chk("reset out_valid", 64'(mon_out_valid[k]), 64'd0);
            chk("reset out", 64'(mon_out[k]), 64'd0);
        end

        // Add 200 + 100
        send(1, 8'd200, 8'd100, 1'b0);
        wait_out(1, lat);
        chk("add latency", 64'(lat), 64'd4);
        chk("add 200+100", 64'(mon_out[1]), 64'(E_ADD));
        release_out(1);

        // Sub 5 - 9
        send(1, 8'd5, 8'd9, 1'b1);
        wait_out(1, lat);
        chk("sub latency", 64'(lat), 64'd4);
        chk("sub 5-9", 64'(mon_out[1]), 64'(E_SUB));
        release_out(1);

        // Back-pressure with an ignored second request
        send(1, 8'd255, 8'd255, 1'b0);
        wait_out(1, lat);
        for (int i = 0; i < 10; i++) begin
            chk("held out", 64'(mon_out[1]), 64'(E_BP));
            chk("held out_valid", 64'(mon_out_valid[1]), 64'd1);
            chk("held in_ready", 64'(mon_in_ready[1]), 64'd0);
            if (i == 3) begin
                drv_a[1] = 8'd1; drv_b[1] = 8'd1; drv_op[1] = 1'b0;
                drv_valid[1] = 1'b1;
            end
            if (i == 4) drv_valid[1] = 1'b0;
            @(posedge clk); #1;
        end
        release_out(1);
        repeat (6) @(posedge clk);
        #1 chk("ignored request produced nothing", 64'(mon_out_valid[1]), 64'd0);

        // Reset during the second digit cycle
        drv_ordy[1] = 1'b1;
        send(1, 8'd100, 8'd50, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid-run reset in_ready", 64'(mon_in_ready[1]), 64'd1);
        chk("mid-run reset out_valid", 64'(mon_out_valid[1]), 64'd0);
        chk("mid-run reset out", 64'(mon_out[1]), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("no output after abort", 64'(mon_out_valid[1]), 64'd0);
        end
        drv_ordy[1] = 1'b0;
        send(1, 8'd7, 8'd7, 1'b0);
        wait_out(1, lat);
        chk("7+7 after reset", 64'(mon_out[1]), 64'(E_77));
        release_out(1);

        // Sweep every DIGIT, edge operands first then random
        for (int k = 0; k < 4; k++) begin
            drv_ordy[k] = 1'b1;
            for (int i = 0; i < 200; i++) begin
                case (i)
                    0:       send(k, 8'd0,   8'd0,   1'b1);
                    1:       send(k, 8'd255, 8'd255, 1'b0);
                    2:       send(k, 8'd0,   8'd255, 1'b1);
                    3:       send(k, 8'd255, 8'd1,   1'b0);
                    default: send(k, W'($urandom), W'($urandom), 1'($urandom));
                endcase
            end
            repeat (12) @(posedge clk);
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
